// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: opcode class encodings, flag bit
// positions and the condition-code selector used by branch resolution.
package pipe_ctrl_pkg;

  localparam int FL_C = 3;
  localparam int FL_Z = 2;
  localparam int FL_S = 1;
  localparam int FL_P = 0;

  // Conditional classes carry the condition code in opcode[2:0].
  localparam logic [7:0] OP_COND_MASK = 8'hF8;
  localparam logic [7:0] OP_JCD       = 8'h08;
  localparam logic [7:0] OP_JCA       = 8'h28;
  localparam logic [7:0] OP_CCD       = 8'h30;
  localparam logic [7:0] OP_CCA       = 8'h38;
  localparam logic [7:0] OP_RTC       = 8'h48;
  localparam logic [7:0] OP_CUD       = 8'h05;
  localparam logic [7:0] OP_CUA       = 8'h06;
  localparam logic [7:0] OP_RTU       = 8'h07;

  typedef enum logic [2:0] {
    CC_C  = 3'b000,
    CC_NC = 3'b001,
    CC_Z  = 3'b010,
    CC_NZ = 3'b011,
    CC_S  = 3'b100,
    CC_NS = 3'b101,
    CC_P  = 3'b110,
    CC_NP = 3'b111
  } cond_e;

  // cc[2:1] picks the flag, cc[0] inverts it.
  function automatic logic eval_cond(input logic [3:0] fl, input cond_e cc);
    logic bit_v;
    case (cc[2:1])
      2'b00:   bit_v = fl[FL_C];
      2'b01:   bit_v = fl[FL_Z];
      2'b10:   bit_v = fl[FL_S];
      default: bit_v = fl[FL_P];
    endcase
    return bit_v ^ cc[0];
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack with sticky overflow/underflow flags. A push when full
// is dropped; a pop when empty returns zero.
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] pop_data,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          full;
  logic          empty;
  logic [PW-1:0] top_idx;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign top_idx   = PW'(count_q - 1'b1);
  assign pop_data  = empty ? '0 : mem_q[top_idx];
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (push) begin
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + 1'b1;
    end else if (pop) begin
      if (empty) udf_d = 1'b1;
      else       count_d = count_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments in every clocked block so all flops sample
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointer alone
  // defines which entries are valid, so resetting the data would only cost area.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[count_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves stage-3 branches, calls and returns: owns the flag register and the
// RAS, and issues a registered PC load plus a counted flush of younger stages.
module branch_resolve_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int AW           = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [7:0]    opcode,
  input  logic          EFL,
  input  logic          S_AL,
  input  logic          LPC,
  input  logic [3:0]    alu_flags,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] return_pc,
  output logic [3:0]    flags,
  output logic          pc_load,
  output logic [AW-1:0] pc_value,
  output logic          flush,
  output logic          ras_overflow,
  output logic          ras_underflow
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    flags_q, flags_d;
  logic          pc_load_q, pc_load_d;
  logic [AW-1:0] pc_value_q, pc_value_d;

  logic          eff, cond, cond_taken;
  logic          is_cjmp, is_ccall, is_cret, is_ucall, is_uret;
  logic          taken, ras_push, ras_pop;
  logic [AW-1:0] ras_top;

  assign flush = (state_q == ST_FLUSH);
  assign eff   = instr_valid && !flush;

  // Condition sees the flags registered before this edge, never alu_flags.
  assign cond       = eval_cond(flags_q, cond_e'(opcode[2:0]));
  assign cond_taken = eff && EFL && LPC && cond;

  assign is_cjmp  = ((opcode & OP_COND_MASK) == OP_JCD) || ((opcode & OP_COND_MASK) == OP_JCA);
  assign is_ccall = ((opcode & OP_COND_MASK) == OP_CCD) || ((opcode & OP_COND_MASK) == OP_CCA);
  assign is_cret  = ((opcode & OP_COND_MASK) == OP_RTC);
  assign is_ucall = (opcode == OP_CUD) || (opcode == OP_CUA);
  assign is_uret  = (opcode == OP_RTU);

  assign taken    = (cond_taken && (is_cjmp || is_ccall || is_cret))
                 || (eff && (is_ucall || is_uret));
  assign ras_push = taken && (is_ccall || is_ucall);
  assign ras_pop  = taken && (is_cret || is_uret);

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (return_pc),
    .pop_data  (ras_top),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    flags_d    = (eff && S_AL) ? alu_flags : flags_q;
    pc_load_d  = taken;
    pc_value_d = pc_value_q;
    if (taken) pc_value_d = ras_pop ? ras_top : branch_target;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (taken) begin
          state_d = ST_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flags_q    <= '0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
    end
  end

  assign flags    = flags_q;
  assign pc_load  = pc_load_q;
  assign pc_value = pc_value_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_branch_resolve_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [7:0]    opcode;
  logic          EFL, S_AL, LPC;
  logic [3:0]    alu_flags;
  logic [AW-1:0] branch_target, return_pc;
  logic [3:0]    flags;
  logic          pc_load;
  logic [AW-1:0] pc_value;
  logic          flush, ras_overflow, ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit #(
    .RAS_DEPTH    (4),
    .FLUSH_CYCLES (2),
    .AW           (AW)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .EFL           (EFL),
    .S_AL          (S_AL),
    .LPC           (LPC),
    .alu_flags     (alu_flags),
    .branch_target (branch_target),
    .return_pc     (return_pc),
    .flags         (flags),
    .pc_load       (pc_load),
    .pc_value      (pc_value),
    .flush         (flush),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic efl, input logic sal,
                       input logic lpc, input logic [3:0] af, input logic [7:0] tgt,
                       input logic [7:0] rpc);
    instr_valid   = v;
    opcode        = op;
    EFL           = efl;
    S_AL          = sal;
    LPC           = lpc;
    alu_flags     = af;
    branch_target = tgt;
    return_pc     = rpc;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_pc_load", 32'(pc_load), 32'h0);
    check("rst_pc_value", 32'(pc_value), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_ovf", 32'(ras_overflow), 32'h0);
    check("rst_udf", 32'(ras_underflow), 32'h0);
    rst_n = 1'b1;

    // ALU op sets Z, then JCD on Z is taken.
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h00, 8'h00);
    tick();
    check("ada_flags", 32'(flags), 32'h4);
    check("ada_no_load", 32'(pc_load), 32'h0);
    drive(1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 4'h0, 8'h3C, 8'h00);
    tick();
    check("jcd_z_load", 32'(pc_load), 32'h1);
    check("jcd_z_value", 32'(pc_value), 32'h3C);
    check("jcd_z_flush1", 32'(flush), 32'h1);
    idle();
    tick();
    check("jcd_z_pulse", 32'(pc_load), 32'h0);
    check("jcd_z_flush2", 32'(flush), 32'h1);
    tick();
    check("jcd_z_flush_end", 32'(flush), 32'h0);

    // JCD on !Z with Z=1 is not taken.
    drive(1'b1, 8'h0B, 1'b1, 1'b0, 1'b1, 4'h0, 8'h55, 8'h00);
    tick();
    check("jcd_nz_load", 32'(pc_load), 32'h0);
    check("jcd_nz_flush", 32'(flush), 32'h0);
    check("jcd_nz_flags", 32'(flags), 32'h4);

    // Set C, then conditional call, then unconditional return.
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 4'b1000, 8'h00, 8'h00);
    tick();
    check("set_c_flags", 32'(flags), 32'h8);
    drive(1'b1, 8'h38, 1'b1, 1'b0, 1'b1, 4'h0, 8'h80, 8'h11);
    tick();
    check("cca_load", 32'(pc_load), 32'h1);
    check("cca_value", 32'(pc_value), 32'h80);
    idle();
    tick();
    tick();
    check("cca_flush_end", 32'(flush), 32'h0);
    drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    tick();
    check("rtu_load", 32'(pc_load), 32'h1);
    check("rtu_value", 32'(pc_value), 32'h11);
    idle();
    tick();
    tick();
    check("ras_empty", 32'(u_dut.u_ras.empty), 32'h1);
    check("rtu_no_udf", 32'(ras_underflow), 32'h0);

    // Five CUA pushes into a 4-deep stack.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 4'h0, 8'(8'h40 + i), 8'(8'hA0 + i));
      tick();
      check($sformatf("cua%0d_value", i), 32'(pc_value), 32'(8'h40 + i));
      check($sformatf("cua%0d_ovf", i), 32'(ras_overflow), (i == 5) ? 32'h1 : 32'h0);
      idle();
      tick();
      tick();
    end

    // Five RTU pops: A4, A3, A2, A1, then empty -> 0 with underflow.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
      tick();
      check($sformatf("rtu%0d_load", i), 32'(pc_load), 32'h1);
      check($sformatf("rtu%0d_value", i), 32'(pc_value), (i == 5) ? 32'h0 : 32'(8'hA5 - i));
      check($sformatf("rtu%0d_udf", i), 32'(ras_underflow), (i == 5) ? 32'h1 : 32'h0);
      idle();
      tick();
      tick();
    end
    check("ovf_sticky", 32'(ras_overflow), 32'h1);

    // Taken JCA (C=1) squashes the next two ALU ops; the third lands.
    drive(1'b1, 8'h28, 1'b1, 1'b0, 1'b1, 4'h0, 8'h5A, 8'h00);
    tick();
    check("jca_value", 32'(pc_value), 32'h5A);
    check("jca_flush", 32'(flush), 32'h1);
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 8'h00);
    tick();
    check("squash1_flags", 32'(flags), 32'h8);
    tick();
    check("squash2_flags", 32'(flags), 32'h8);
    check("squash2_flush", 32'(flush), 32'h0);
    tick();
    check("alu3_flags", 32'(flags), 32'hF);

    // Flag update and branch together: condition uses old Z=1, so !Z not taken.
    drive(1'b1, 8'h0B, 1'b1, 1'b1, 1'b1, 4'h0, 8'h66, 8'h00);
    tick();
    check("same_cyc_load", 32'(pc_load), 32'h0);
    check("same_cyc_flags", 32'(flags), 32'h0);

    // Now Z=0: !Z taken, then reset on the first flush cycle.
    drive(1'b1, 8'h0B, 1'b1, 1'b0, 1'b1, 4'h0, 8'h77, 8'h00);
    tick();
    check("pre_rst_flush", 32'(flush), 32'h1);
    check("pre_rst_load", 32'(pc_load), 32'h1);
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_flush", 32'(flush), 32'h0);
    check("mid_rst_load", 32'(pc_load), 32'h0);
    check("mid_rst_flags", 32'(flags), 32'h0);
    check("mid_rst_value", 32'(pc_value), 32'h0);
    check("mid_rst_ovf", 32'(ras_overflow), 32'h0);
    check("mid_rst_udf", 32'(ras_underflow), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_flush", 32'(flush), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the stage-3 control bundle (EFL, S_AL, LPC) together with the opcode, and acts on it.
- Holds the architectural flag register and evaluates flag conditions.
- Owns a small return-address stack for calls and returns.
- On a taken branch it issues a registered PC load and a multi-cycle flush of the younger pipeline stages.
- Sits between stage 3 and the PC/fetch logic.

Parameters:
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- FLUSH_CYCLES, 2, cycles younger stages are squashed after a taken branch (1..7).
- AW, 8, PC/address width.

Ports:
- clk  in  1  system-wide clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  stage-3 slot holds a real instruction
- opcode  in  8  stage-3 opcode
- EFL  in  1  condition-evaluate enable from stage-3 control
- S_AL  in  1  ALU result selected; flags to be updated
- LPC  in  1  conditional PC-load request
- alu_flags  in  4  {C,Z,S,P} from the ALU this cycle
- branch_target  in  AW  resolved direct/absolute target
- return_pc  in  AW  address of the instruction following the call
- flags  out  4  architectural {C,Z,S,P}
- pc_load  out  1  load PC this cycle
- pc_value  out  AW  value to load
- flush  out  1  squash younger stages
- ras_overflow  out  1  sticky: push when full
- ras_underflow  out  1  sticky: pop when empty

Behaviour:
- Reset (async, rst_n low): flags=0, pc_load=0, pc_value=0, flush=0, flush counter=0, RAS pointer=0, both sticky errors=0. Reset mid-flush aborts the flush immediately.
- Effective instruction: `eff = instr_valid && !flush`. Any instruction arriving while flush=1 is ignored completely: no flag update, no branch, no stack action.
- Flag update: if `eff && S_AL`, then flags <= alu_flags at the clock edge.
- Condition select `fl = opcode[2:0]`:
  - 000 C, 001 !C
  - 010 Z, 011 !Z
  - 100 S, 101 !S
  - 110 P, 111 !P
  - Evaluated against the registered flags value before this edge (no same-cycle forwarding of alu_flags).
- Instruction classes, decoded on opcode:
  - Conditional jump (JCD 0000_1xxx, JCA 0010_1xxx): taken if `eff && EFL && LPC && cond`. pc_value <= branch_target.
  - Conditional call (CCD 0011_0xxx, CCA 0011_1xxx): same taken rule. Push return_pc, then pc_value <= branch_target.
  - Conditional return (RTC 0100_1xxx): same taken rule. Pop; pc_value <= popped entry.
  - Unconditional (CUD 0000_0101, CUA 0000_0110 push-and-jump; RTU 0000_0111 pop): taken whenever eff, regardless of EFL/LPC. JUD/JUA are resolved upstream and are not acted on here.
  - Not-taken conditional: no stack action, no pc_load.
- Latency: pc_load and pc_value are registered, asserted exactly one cycle after the decisive cycle, and pc_load is a one-cycle pulse.
- Flush: on a taken decision, flush rises together with pc_load and stays high for FLUSH_CYCLES consecutive cycles (down-counter), then drops.
- RAS behaviour:
  - Push when full: entry dropped, pointer unchanged, ras_overflow sets; the jump still happens.
  - Pop when empty: pc_value=0, ras_underflow sets; the PC load still happens.
  - Sticky errors clear only on reset.
- State machine: IDLE -> (taken) FLUSH, with counter loaded to FLUSH_CYCLES-1. FLUSH -> IDLE when counter==0. No new branch can be taken in FLUSH.
- Simultaneous S_AL and branch in one instruction: flag update and branch evaluation both occur, and the condition uses the old flags.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - opcode class constants (OP_JCD, OP_JCA, OP_CCD, OP_CCA, OP_RTC, OP_CUD, OP_CUA, OP_RTU masks/values)
  - flag index constants (FL_C=3, FL_Z=2, FL_S=1, FL_P=0)
  - condition-code enum
- Sub-module `return_addr_stack`: RAS_DEPTH x AW, with push/pop/full/empty/overflow/underflow.

Test Plan:
- Reset mid-flush: take a jump, then pull rst_n low on the first flush cycle -> flush=0, pc_load=0, flags=0 immediately.
- ADA with S_AL=1, alu_flags=4'b0100, next cycle JCD fl=010, EFL=LPC=1, branch_target=8'h3C -> next cycle pc_load=1, pc_value=8'h3C, flush high 2 cycles.
- Same setup with fl=011 -> pc_load stays 0, flush 0, flags hold 4'b0100.
- CCA fl=000 with C=1, return_pc=8'h11, target=8'h80; then after the flush, RTU -> first pc_value=8'h80, then pc_value=8'h11; RAS empty afterwards.
- 5 CUA pushes with RAS_DEPTH=4 -> ras_overflow=1 after the 5th. Then 5 RTU -> 4th pop returns 1st pushed address, 5th pop gives pc_value=0 and ras_underflow=1.
- Taken JCA followed by 2 valid ALU instructions with S_AL=1, alu_flags=4'hF -> both squashed, flags unchanged. Third instruction updates flags to 4'hF.
